// File: rtl/icache_nway_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_nway_if
// Purpose  : Groups the fetch-side, decode-side and line-refill signals of the
//            N-way instruction cache into one bundle.
// Ports    : pc / in_stall / in_flush / in_invalidate  - fetch-side controls
//            in_refill_valid / in_refill_data          - refill line delivery
//            out_refill_req / out_refill_addr          - refill line request
//            out_instr / out_pc / out_valid            - decode register
//            out_miss / out_stall                      - combinational status
//            out_hit_count / out_miss_count            - performance counters
// Modports : slave  - the cache itself
//            master - the surrounding fetch / bus logic
// Revision : 1.0 - initial release
// ============================================================================
interface icache_nway_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int LINE_BYTES     = 64
);
    logic [BUS_DATA_WIDTH-1:0] pc;
    logic                      in_stall;
    logic                      in_flush;
    logic                      in_invalidate;
    logic                      in_refill_valid;
    logic [LINE_BYTES*8-1:0]   in_refill_data;
    logic                      out_refill_req;
    logic [BUS_DATA_WIDTH-1:0] out_refill_addr;
    logic [31:0]               out_instr;
    logic [BUS_DATA_WIDTH-1:0] out_pc;
    logic                      out_valid;
    logic                      out_miss;
    logic                      out_stall;
    logic [31:0]               out_hit_count;
    logic [31:0]               out_miss_count;

    modport slave (
        input  pc, in_stall, in_flush, in_invalidate, in_refill_valid, in_refill_data,
        output out_refill_req, out_refill_addr, out_instr, out_pc, out_valid,
               out_miss, out_stall, out_hit_count, out_miss_count
    );

    modport master (
        output pc, in_stall, in_flush, in_invalidate, in_refill_valid, in_refill_data,
        input  out_refill_req, out_refill_addr, out_instr, out_pc, out_valid,
               out_miss, out_stall, out_hit_count, out_miss_count
    );
endinterface
`default_nettype wire

// File: rtl/icache_nway.sv
`default_nettype none
// ============================================================================
// Module   : icache_nway
// Purpose  : Read-only N-way set-associative L1 instruction cache with
//            per-set tree-PLRU replacement, a request/valid line refill port
//            and a full-cache invalidate sweep. Registers the fetched
//            instruction and PC into the decode stage.
// Ports    : clk   - clock, all state changes on the rising edge
//            reset - asynchronous, active-low reset
//            bus   - icache_nway_if.slave (fetch, refill, decode, counters)
// Revision : 1.0 - initial release
// ============================================================================
module icache_nway #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int LINE_BYTES     = 64,
    parameter int SETS           = 512,
    parameter int WAYS           = 2
) (
    input  wire logic    clk,
    input  wire logic    reset,
    icache_nway_if.slave bus
);
    localparam int OFF  = $clog2(LINE_BYTES);
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = BUS_DATA_WIDTH - IDX - OFF;
    localparam int LOGW = $clog2(WAYS);
    localparam int WW   = (LOGW > 0) ? LOGW : 1;
    localparam int PW   = (WAYS > 1) ? (WAYS - 1) : 1;
    localparam int LW   = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MISS  = 2'd1,
        S_INVAL = 2'd2
    } state_t;

    // Tree-PLRU: heap-ordered nodes, node n stored at bit n-1.
    // A node bit of 0 points the victim to the left subtree, 1 to the right.
    function automatic logic [WW-1:0] plru_victim(input logic [PW-1:0] bits);
        int node;
        logic [PW-1:0] sh;
        node = 1;
        for (int l = 0; l < LOGW; l++) begin
            sh   = bits >> (node - 1);
            node = sh[0] ? (2 * node + 1) : (2 * node);
        end
        return WW'(node - WAYS);
    endfunction

    // Make 'way' most recently used: every node on its path points away from it.
    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] bits,
                                                 input logic [WW-1:0] way);
        int node;
        logic [WW-1:0] wsh;
        logic [PW-1:0] r;
        r    = bits;
        node = 1;
        for (int l = 0; l < LOGW; l++) begin
            wsh  = way >> (LOGW - 1 - l);
            r    = (r & ~(PW'(1) << (node - 1))) | (PW'(!wsh[0]) << (node - 1));
            node = 2 * node + (wsh[0] ? 1 : 0);
        end
        return r;
    endfunction

    // Storage
    logic [WAYS-1:0] valid_q [SETS];
    logic [PW-1:0]   plru_q  [SETS];
    logic [TAG-1:0]  tag_q   [SETS][WAYS];
    logic [LW-1:0]   data_q  [SETS][WAYS];

    // Control state
    state_t                    state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic                      pend_q, pend_d;
    logic [IDX-1:0]            inv_set_q, inv_set_d;
    logic [31:0]               hit_cnt_q, miss_cnt_q;
    logic [31:0]               instr_q;
    logic [BUS_DATA_WIDTH-1:0] dpc_q;
    logic                      dvalid_q;

    // Lookup
    logic [TAG-1:0]  w_tag;
    logic [IDX-1:0]  w_idx;
    logic [OFF-3:0]  w_word;
    logic            w_hit;
    logic [WW-1:0]   w_hit_way;
    logic [LW-1:0]   w_line;
    logic [31:0]     w_hit_word;

    assign w_tag  = bus.pc[BUS_DATA_WIDTH-1:IDX+OFF];
    assign w_idx  = bus.pc[IDX+OFF-1:OFF];
    assign w_word = bus.pc[OFF-1:2];

    // Descending scan so the lowest matching way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w_idx][w] && (tag_q[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WW'(w);
            end
        end
    end

    assign w_line     = data_q[w_idx][w_hit_way];
    assign w_hit_word = w_line[w_word*32 +: 32];

    // Refill victim for the latched miss set: lowest invalid way, else PLRU.
    logic [IDX-1:0]  w_midx;
    logic [TAG-1:0]  w_mtag;
    logic [WAYS-1:0] w_mvalid;
    logic [WW-1:0]   w_victim;

    assign w_midx   = miss_addr_q[IDX+OFF-1:OFF];
    assign w_mtag   = miss_addr_q[BUS_DATA_WIDTH-1:IDX+OFF];
    assign w_mvalid = valid_q[w_midx];

    always_comb begin
        w_victim = plru_victim(plru_q[w_midx]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_mvalid[w]) begin
                w_victim = WW'(w);
            end
        end
    end

    // Next-state logic
    logic w_lookup, w_fill, w_clear, w_miss, w_stall;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        pend_d      = pend_q;
        inv_set_d   = inv_set_q;
        w_lookup    = 1'b0;
        w_fill      = 1'b0;
        w_clear     = 1'b0;
        w_miss      = 1'b0;
        w_stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_lookup = !bus.in_stall;
                if (w_lookup && !w_hit) begin
                    // A miss wins over a same-cycle invalidate; the invalidate
                    // is remembered and runs once the fill completes.
                    w_miss      = 1'b1;
                    w_stall     = 1'b1;
                    state_d     = S_MISS;
                    miss_addr_d = {bus.pc[BUS_DATA_WIDTH-1:OFF], {OFF{1'b0}}};
                    pend_d      = pend_q | bus.in_invalidate;
                end else if (bus.in_invalidate) begin
                    state_d   = S_INVAL;
                    inv_set_d = '0;
                end
            end
            S_MISS: begin
                w_stall = 1'b1;
                if (bus.in_invalidate) begin
                    pend_d = 1'b1;
                end
                if (bus.in_refill_valid) begin
                    w_fill = 1'b1;
                    if (pend_q || bus.in_invalidate) begin
                        state_d   = S_INVAL;
                        inv_set_d = '0;
                        pend_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_INVAL: begin
                w_stall = 1'b1;
                w_clear = 1'b1;
                if (bus.in_invalidate) begin
                    pend_d = 1'b1;
                end
                if (inv_set_q == IDX'(SETS - 1)) begin
                    inv_set_d = '0;
                    // A request that arrived mid-sweep triggers a fresh sweep.
                    if (pend_q || bus.in_invalidate) begin
                        pend_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    inv_set_d = inv_set_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers, counters and decode register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            miss_addr_q <= '0;
            pend_q      <= 1'b0;
            inv_set_q   <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            instr_q     <= '0;
            dpc_q       <= '0;
            dvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            pend_q      <= pend_d;
            inv_set_q   <= inv_set_d;
            if (w_lookup) begin
                if (w_hit) begin
                    if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
            if (!bus.in_stall) begin
                if (w_stall) begin
                    dvalid_q <= 1'b0;
                end else if (bus.in_flush) begin
                    instr_q  <= '0;
                    dpc_q    <= '0;
                    dvalid_q <= 1'b0;
                end else begin
                    instr_q  <= w_hit_word;
                    dpc_q    <= bus.pc;
                    dvalid_q <= 1'b1;
                end
            end
        end
    end

    // Valid and PLRU bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (w_clear) begin
                valid_q[inv_set_q] <= '0;
                plru_q[inv_set_q]  <= '0;
            end
            if (w_fill) begin
                valid_q[w_midx][w_victim] <= 1'b1;
                plru_q[w_midx]            <= plru_touch(plru_q[w_midx], w_victim);
            end else if (w_lookup && w_hit) begin
                plru_q[w_idx] <= plru_touch(plru_q[w_idx], w_hit_way);
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            tag_q[w_midx][w_victim]  <= w_mtag;
            data_q[w_midx][w_victim] <= bus.in_refill_data;
        end
    end

    assign bus.out_refill_req  = (state_q == S_MISS);
    assign bus.out_refill_addr = miss_addr_q;
    assign bus.out_instr       = instr_q;
    assign bus.out_pc          = dpc_q;
    assign bus.out_valid       = dvalid_q;
    // Held at 0 while reset is asserted so every output reads 0 during reset.
    assign bus.out_miss        = reset & w_miss;
    assign bus.out_stall       = reset & w_stall;
    assign bus.out_hit_count   = hit_cnt_q;
    assign bus.out_miss_count  = miss_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_icache_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_nway
// Purpose  : Directed self-checking bench for icache_nway (default geometry:
//            64-bit PC, 64-byte lines, 512 sets, 2 ways).
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_nway;
    localparam int SETS      = 512;
    localparam int LINE_BITS = 512;

    logic clk;
    logic reset;
    int   checks;
    int   passes;
    int   exp_hit;
    int   exp_miss;

    icache_nway_if #(.BUS_DATA_WIDTH(64), .LINE_BYTES(64)) bus ();

    icache_nway #(
        .BUS_DATA_WIDTH(64),
        .LINE_BYTES    (64),
        .SETS          (SETS),
        .WAYS          (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line content: word k of the line at base B is 0xC0DE0000 ^ (B + 4k).
    function automatic logic [LINE_BITS-1:0] make_line(input logic [63:0] a);
        logic [LINE_BITS-1:0] l;
        logic [31:0]          base;
        base = a[31:0] & ~32'h3F;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = 32'hC0DE0000 ^ (base + 32'(k * 4));
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Miss on addr, refill after one request cycle, then the re-lookup hit.
    task automatic miss_fill(input logic [63:0] addr, output logic saw_miss,
                             output logic [31:0] saw_instr);
        bus.in_stall = 1'b0;
        bus.pc       = addr;
        #1;
        saw_miss = bus.out_miss;
        tick();
        exp_miss++;
        bus.in_refill_valid = 1'b1;
        bus.in_refill_data  = make_line(addr);
        tick();
        bus.in_refill_valid = 1'b0;
        tick();
        exp_hit++;
        saw_instr    = bus.out_instr;
        bus.in_stall = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.out_instr !== 32'd0) $display("FAIL rst_instr: got %h want 0", bus.out_instr); else passes++;
        checks++; if (bus.out_pc !== 64'd0) $display("FAIL rst_pc: got %h want 0", bus.out_pc); else passes++;
        checks++; if (bus.out_refill_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.out_refill_req); else passes++;
        checks++; if (bus.out_refill_addr !== 64'd0) $display("FAIL rst_addr: got %h want 0", bus.out_refill_addr); else passes++;
        checks++; if (bus.out_hit_count !== 32'd0 || bus.out_miss_count !== 32'd0)
            $display("FAIL rst_counters: got %0d/%0d want 0/0", bus.out_hit_count, bus.out_miss_count); else passes++;
    endtask

    task automatic test_cold_miss();
        int n;
        bus.pc       = 64'h1000;
        bus.in_stall = 1'b0;
        #1;
        checks++; if (bus.out_miss !== 1'b1 || bus.out_stall !== 1'b1)
            $display("FAIL cold_miss_comb: got miss=%b stall=%b want 1/1", bus.out_miss, bus.out_stall); else passes++;
        tick();
        exp_miss++;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_refill_req === 1'b1 && bus.out_refill_addr === 64'h1000) n++;
            if (i < 4) tick();
        end
        checks++; if (n != 5) $display("FAIL cold_req_cycles: got %0d want 5", n); else passes++;
        bus.in_refill_valid = 1'b1;
        bus.in_refill_data  = make_line(64'h1000);
        tick();
        bus.in_refill_valid = 1'b0;
        checks++; if (bus.out_refill_req !== 1'b0) $display("FAIL cold_req_drop: got %b want 0", bus.out_refill_req); else passes++;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_stall !== 1'b0)
            $display("FAIL cold_after_fill: got valid=%b stall=%b want 0/0", bus.out_valid, bus.out_stall); else passes++;
        tick();
        exp_hit++;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hC0DE1000 || bus.out_pc !== 64'h1000)
            $display("FAIL cold_hit: got v=%b instr=%h pc=%h want 1/c0de1000/1000", bus.out_valid, bus.out_instr, bus.out_pc); else passes++;
        checks++; if (bus.out_hit_count !== 32'd1 || bus.out_miss_count !== 32'd1)
            $display("FAIL cold_counters: got %0d/%0d want 1/1", bus.out_hit_count, bus.out_miss_count); else passes++;
        bus.in_stall = 1'b1;
    endtask

    task automatic test_sequential();
        int stalls;
        logic [31:0] a;
        stalls       = 0;
        bus.in_stall = 1'b0;
        for (int k = 0; k < 16; k++) begin
            a      = 32'h1000 + 32'(4 * k);
            bus.pc = {32'd0, a};
            #1;
            if (bus.out_stall !== 1'b0) stalls++;
            tick();
            exp_hit++;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== (32'hC0DE0000 ^ a))
                $display("FAIL seq_word%0d: got v=%b instr=%h want 1/%h", k, bus.out_valid, bus.out_instr, 32'hC0DE0000 ^ a); else passes++;
        end
        checks++; if (stalls != 0) $display("FAIL seq_stalls: got %0d want 0", stalls); else passes++;
        bus.in_stall = 1'b1;
    endtask

    task automatic test_plru();
        logic        m;
        logic [31:0] ins;
        miss_fill(64'h0, m, ins);
        checks++; if (m !== 1'b1) $display("FAIL plru_fill_a: got miss=%b want 1", m); else passes++;
        miss_fill(64'h8000, m, ins);
        checks++; if (m !== 1'b1) $display("FAIL plru_fill_b: got miss=%b want 1", m); else passes++;
        bus.in_stall = 1'b0;
        bus.pc       = 64'h0;
        #1;
        checks++; if (bus.out_miss !== 1'b0) $display("FAIL plru_touch_a: got miss=%b want 0", bus.out_miss); else passes++;
        tick();
        exp_hit++;
        bus.in_stall = 1'b1;
        miss_fill(64'h10000, m, ins);
        checks++; if (m !== 1'b1 || ins !== 32'hC0DF0000)
            $display("FAIL plru_fill_c: got miss=%b instr=%h want 1/c0df0000", m, ins); else passes++;
        bus.in_stall = 1'b0;
        bus.pc       = 64'h0;
        #1;
        checks++; if (bus.out_miss !== 1'b0) $display("FAIL plru_a_kept: got miss=%b want 0", bus.out_miss); else passes++;
        tick();
        exp_hit++;
        checks++; if (bus.out_instr !== 32'hC0DE0000) $display("FAIL plru_a_data: got %h want c0de0000", bus.out_instr); else passes++;
        bus.in_stall = 1'b1;
        miss_fill(64'h8000, m, ins);
        checks++; if (m !== 1'b1) $display("FAIL plru_b_evicted: got miss=%b want 1", m); else passes++;
        checks++; if (bus.out_hit_count !== 32'(exp_hit) || bus.out_miss_count !== 32'(exp_miss))
            $display("FAIL plru_counters: got %0d/%0d want %0d/%0d", bus.out_hit_count, bus.out_miss_count, exp_hit, exp_miss); else passes++;
    endtask

    task automatic test_invalidate();
        int n;
        // Invalidate from IDLE
        bus.in_invalidate = 1'b1;
        tick();
        bus.in_invalidate = 1'b0;
        bus.in_stall      = 1'b0;
        bus.pc            = 64'h1000;
        #1;
        n = 0;
        while (bus.out_stall === 1'b1 && bus.out_miss === 1'b0 && n < SETS + 50) begin
            tick();
            n++;
        end
        checks++; if (n != SETS) $display("FAIL inval_idle_cycles: got %0d want %0d", n, SETS); else passes++;
        checks++; if (bus.out_miss !== 1'b1) $display("FAIL inval_then_miss: got %b want 1", bus.out_miss); else passes++;
        tick();
        exp_miss++;
        bus.in_refill_valid = 1'b1;
        bus.in_refill_data  = make_line(64'h1000);
        tick();
        bus.in_refill_valid = 1'b0;
        tick();
        exp_hit++;
        // Invalidate while a miss is outstanding
        bus.pc = 64'h2000;
        #1;
        tick();
        exp_miss++;
        bus.in_invalidate = 1'b1;
        tick();
        bus.in_invalidate = 1'b0;
        checks++; if (bus.out_refill_req !== 1'b1 || bus.out_refill_addr !== 64'h2000)
            $display("FAIL inval_miss_req: got req=%b addr=%h want 1/2000", bus.out_refill_req, bus.out_refill_addr); else passes++;
        bus.in_refill_valid = 1'b1;
        bus.in_refill_data  = make_line(64'h2000);
        tick();
        bus.in_refill_valid = 1'b0;
        checks++; if (bus.out_refill_req !== 1'b0) $display("FAIL inval_miss_fill: got req=%b want 0", bus.out_refill_req); else passes++;
        n = 0;
        while (bus.out_stall === 1'b1 && bus.out_miss === 1'b0 && n < SETS + 50) begin
            tick();
            n++;
        end
        checks++; if (n != SETS) $display("FAIL inval_miss_cycles: got %0d want %0d", n, SETS); else passes++;
        checks++; if (bus.out_miss !== 1'b1) $display("FAIL inval_miss_swept: got %b want 1", bus.out_miss); else passes++;
        tick();
        exp_miss++;
        bus.in_refill_valid = 1'b1;
        bus.in_refill_data  = make_line(64'h2000);
        tick();
        bus.in_refill_valid = 1'b0;
        tick();
        exp_hit++;
        bus.in_stall = 1'b1;
        checks++; if (bus.out_hit_count !== 32'(exp_hit) || bus.out_miss_count !== 32'(exp_miss))
            $display("FAIL inval_counters: got %0d/%0d want %0d/%0d", bus.out_hit_count, bus.out_miss_count, exp_hit, exp_miss); else passes++;
    endtask

    task automatic test_flush_stall();
        logic        m;
        logic [31:0] ins;
        miss_fill(64'h1000, m, ins);
        bus.in_stall = 1'b0;
        bus.pc       = 64'h1004;
        tick();
        exp_hit++;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hC0DE1004)
            $display("FAIL flush_pre: got v=%b instr=%h want 1/c0de1004", bus.out_valid, bus.out_instr); else passes++;
        bus.in_flush = 1'b1;
        tick();
        exp_hit++;
        bus.in_flush = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 || bus.out_pc !== 64'd0)
            $display("FAIL flush_bubble: got v=%b instr=%h pc=%h want 0/0/0", bus.out_valid, bus.out_instr, bus.out_pc); else passes++;
        tick();
        exp_hit++;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h1004)
            $display("FAIL flush_resume: got v=%b pc=%h want 1/1004", bus.out_valid, bus.out_pc); else passes++;
        bus.in_stall = 1'b1;
        bus.pc       = 64'h1008;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h1004 || bus.out_instr !== 32'hC0DE1004)
            $display("FAIL stall_hold: got v=%b pc=%h instr=%h want 1/1004/c0de1004", bus.out_valid, bus.out_pc, bus.out_instr); else passes++;
        checks++; if (bus.out_hit_count !== 32'(exp_hit)) $display("FAIL stall_no_count: got %0d want %0d", bus.out_hit_count, exp_hit); else passes++;
        bus.in_stall = 1'b0;
        bus.pc       = 64'h3000;
        #1;
        tick();
        exp_miss++;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 64'h1004)
            $display("FAIL miss_bubble: got v=%b pc=%h want 0/1004", bus.out_valid, bus.out_pc); else passes++;
        bus.in_stall        = 1'b1;
        bus.in_refill_valid = 1'b1;
        bus.in_refill_data  = make_line(64'h3000);
        tick();
        bus.in_refill_valid = 1'b0;
        checks++; if (bus.out_refill_req !== 1'b0) $display("FAIL stall_fill_accepted: got req=%b want 0", bus.out_refill_req); else passes++;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 64'h1004 || bus.out_miss !== 1'b0)
            $display("FAIL stall_fill_held: got v=%b pc=%h miss=%b want 0/1004/0", bus.out_valid, bus.out_pc, bus.out_miss); else passes++;
        tick();
        bus.in_stall = 1'b0;
        #1;
        checks++; if (bus.out_miss !== 1'b0) $display("FAIL stall_fill_hit: got miss=%b want 0", bus.out_miss); else passes++;
        tick();
        exp_hit++;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hC0DE3000)
            $display("FAIL stall_fill_data: got v=%b instr=%h want 1/c0de3000", bus.out_valid, bus.out_instr); else passes++;
        bus.in_stall = 1'b1;
    endtask

    task automatic test_reset_mid_miss();
        bus.in_stall = 1'b0;
        bus.pc       = 64'h5000;
        #1;
        tick();
        checks++; if (bus.out_refill_req !== 1'b1) $display("FAIL rmm_in_miss: got req=%b want 1", bus.out_refill_req); else passes++;
        #2;
        reset = 1'b0;
        #1;
        exp_hit  = 0;
        exp_miss = 0;
        checks++; if (bus.out_refill_req !== 1'b0 || bus.out_refill_addr !== 64'd0)
            $display("FAIL rmm_req: got req=%b addr=%h want 0/0", bus.out_refill_req, bus.out_refill_addr); else passes++;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 || bus.out_pc !== 64'd0)
            $display("FAIL rmm_decode: got v=%b instr=%h pc=%h want 0/0/0", bus.out_valid, bus.out_instr, bus.out_pc); else passes++;
        checks++; if (bus.out_hit_count !== 32'd0 || bus.out_miss_count !== 32'd0 || bus.out_stall !== 1'b0 || bus.out_miss !== 1'b0)
            $display("FAIL rmm_misc: got %0d/%0d stall=%b miss=%b want 0/0/0/0", bus.out_hit_count, bus.out_miss_count, bus.out_stall, bus.out_miss); else passes++;
        bus.in_stall        = 1'b1;
        bus.in_refill_valid = 1'b1;
        bus.in_refill_data  = make_line(64'h5000);
        tick();
        reset = 1'b1;
        tick();
        bus.in_refill_valid = 1'b0;
        checks++; if (bus.out_refill_req !== 1'b0) $display("FAIL rmm_stale_ignored: got req=%b want 0", bus.out_refill_req); else passes++;
        bus.in_stall = 1'b0;
        #1;
        checks++; if (bus.out_miss !== 1'b1) $display("FAIL rmm_cold_5000: got miss=%b want 1", bus.out_miss); else passes++;
        bus.pc = 64'h1000;
        #1;
        checks++; if (bus.out_miss !== 1'b1) $display("FAIL rmm_cold_1000: got miss=%b want 1", bus.out_miss); else passes++;
        tick();
        exp_miss++;
        checks++; if (bus.out_miss_count !== 32'(exp_miss) || bus.out_refill_addr !== 64'h1000)
            $display("FAIL rmm_refetch: got cnt=%0d addr=%h want %0d/1000", bus.out_miss_count, bus.out_refill_addr, exp_miss); else passes++;
        bus.in_stall = 1'b1;
    endtask

    initial begin
        checks              = 0;
        passes              = 0;
        exp_hit             = 0;
        exp_miss            = 0;
        reset               = 1'b0;
        bus.pc              = '0;
        bus.in_stall        = 1'b1;
        bus.in_flush        = 1'b0;
        bus.in_invalidate   = 1'b0;
        bus.in_refill_valid = 1'b0;
        bus.in_refill_data  = '0;
        repeat (3) tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_cold_miss();
        test_sequential();
        test_plru();
        test_invalidate();
        test_flush_stall();
        test_reset_mid_miss();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/icache_nway.md
# icache_nway

Parametrised N-way set-associative, read-only L1 instruction cache with per-set tree-PLRU replacement, a request/valid line-refill port and a full-cache invalidate sweep. It sits between the fetch PC register and the decode pipeline register. It looks up the PC every unstalled cycle and registers the fetched instruction and PC into decode. On a miss it stalls fetch and requests the line from the bus-side line fetcher.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64: PC/address width.
- LINE_BYTES, 64: line size; power of two, ≥ 8.
- SETS, 512: number of sets; power of two.
- WAYS, 2: associativity; power of two, 1..8.
- Derived: OFF = log2(LINE_BYTES), IDX = log2(SETS), TAG = BUS_DATA_WIDTH−IDX−OFF.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- pc, input, BUS_DATA_WIDTH: fetch address; bits [1:0] ignored.
- in_stall, input, 1: downstream stall (hazard unit or dcache); freezes lookup and outputs.
- in_flush, input, 1: jump/ecall kill; writes a bubble into decode.
- in_invalidate, input, 1: one-cycle pulse; invalidate every line.
- in_refill_valid, input, 1: refill line present on in_refill_data this cycle.
- in_refill_data, input, LINE_BYTES*8: refill line, byte 0 in bits [7:0].
- out_refill_req, output, 1: line request, level, held until accepted.
- out_refill_addr, output, BUS_DATA_WIDTH: line-aligned miss address (low OFF bits zero).
- out_instr, output, 32: registered instruction to decode.
- out_pc, output, BUS_DATA_WIDTH: registered PC to decode.
- out_valid, output, 1: out_instr/out_pc hold a real instruction.
- out_miss, output, 1: combinational; lookup missed this cycle (IDLE only).
- out_stall, output, 1: combinational; fetch must hold the PC.
- out_hit_count, out_miss_count, output, 32 each: saturating performance counters.

## Operation
- Address split: tag = pc[BUS_DATA_WIDTH-1:IDX+OFF], index = pc[IDX+OFF-1:OFF], word = pc[OFF-1:2].
- Storage per way: valid bit, TAG tag, line data. Per set: WAYS−1 tree-PLRU bits.
- State IDLE, hit: a way is valid and its tag matches. The PLRU is updated to point away from the hit way. out_miss=0, out_stall=0.
- State IDLE, miss: out_miss=1 and out_stall=1. Go to MISS and latch the line address.
- State MISS: out_refill_req=1 with the latched out_refill_addr; out_stall=1.
  - Victim is the lowest-index invalid way, else the PLRU victim.
  - When in_refill_valid=1, write data, tag and valid into the victim and make it MRU. Return to IDLE.
- State INVAL: a set counter runs 0..SETS−1 and clears all valid bits and PLRU bits of one set per cycle; out_stall=1. After set SETS−1, return to IDLE.
- in_invalidate in IDLE: enter INVAL. In MISS or INVAL: set a pending flag. The pending invalidate starts after the fill completes, or restarts the sweep at set 0.
- Decode register: updated when in_stall=0 and out_stall=0.
  - in_flush=1: out_instr=0, out_pc=0, out_valid=0.
  - Otherwise: out_instr = hit word, out_pc = pc, out_valid=1.
- While out_stall=1 and in_stall=0: out_valid is cleared to 0, creating a bubble.
- in_stall=1: no lookup, no PLRU update, no counter update, decode register held, out_miss=0. Refill acceptance in MISS and the INVAL sweep still proceed.
- Counters: count once per unstalled IDLE lookup; saturate at 2^32−1.
- in_flush during MISS: the refill completes and fills normally (no abort).

## Timing
- Reset (asynchronous, reset low): state=IDLE, all valid and PLRU bits 0, invalidate-pending 0. All outputs 0: out_instr, out_pc, out_valid, out_refill_req, out_refill_addr, counters.
- Hit: instruction visible on out_instr one edge after pc is presented.
- Miss with refill at memory latency L (cycles from out_refill_req rising to in_refill_valid):
  - out_refill_req rises at edge 1.
  - Fill occurs at edge 1+L.
  - The re-lookup hits, and out_valid=1 one edge later.
- in_refill_valid outside MISS: ignored.
- Invalidate costs exactly SETS stall cycles.
- Reset deasserted mid-miss: restart cold; a stale in_refill_valid is ignored.

## Test plan
- Cold miss: pc=0x1000, refill after L=5 → out_refill_req=1 with addr 0x1000 for 5 cycles; then hit; out_instr = word 0 of the line; miss_count=1, hit_count=1.
- Sequential hits: pc 0x1000..0x103C → 16 consecutive out_valid=1 words, zero stall cycles.
- PLRU, WAYS=2: fill tags A,B in set 0, touch A, then miss C → B is evicted; a later access to A hits and B misses.
- Invalidate in IDLE → SETS stall cycles; next access to 0x1000 misses. Invalidate during MISS → fill completes, then the sweep runs.
- Flush with in_stall: in_flush on a hit → out_valid=0, out_instr=0, out_pc=0. in_stall=1 during refill → fill accepted, decode register held.
- Asynchronous reset asserted mid-MISS → all outputs 0 immediately; the next access misses.
